msrv32_fetch_queue: RTL and testbench
=====================================

MSRV32_FETCH_QUEUE -- requirements
Module: msrv32_fetch_queue

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port imem_req_out  output  1  instruction-memory request strobe.
REQ-005 SHALL have port imem_addr_out  output  32  request word address (bits[1:0] always 0).
REQ-006 SHALL have port imem_ack_in  input  1  response valid; at least 1 cycle after request.
REQ-007 SHALL have port imem_rdata_in  input  32  response instruction word.
REQ-008 SHALL have port branch_taken_in  input  1  redirect strobe from execute.
REQ-009 SHALL have port branch_target_in  input  32  redirect address; bits[1:0] ignored.
REQ-010 SHALL have port stall_in  input  1  decode not ready; head is held.
REQ-011 SHALL have port instr_valid_out  output  1  head entry valid.
REQ-012 SHALL have port instr_out  output  32  head instruction, drives decode instruction input.
REQ-013 SHALL have port instr_pc_out  output  32  PC of head instruction.
REQ-014 SHALL have port flush_out  output  1  drives decode flush input; forces NOP (32'h00000013) on bubbles.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr}; outputs are the registered head entry.
REQ-016 SHALL run a 3-state FSM: IDLE (nothing outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard).
REQ-017 In IDLE, SHALL assert imem_req_out when occupancy < 2 and branch_taken_in = 0, with imem_addr_out = pc_q; on that cycle pc_q += 4 (mod 2^32) and state -> WAIT.
REQ-018 In WAIT, imem_ack_in SHALL push {issued pc, imem_rdata_in} and return to IDLE; no new request in the ack cycle.
REQ-019 In DROP, imem_ack_in SHALL be discarded and return to IDLE.
REQ-020 At most one request SHALL be outstanding; FIFO SHALL never overflow.
REQ-021 Pop SHALL occur when instr_valid_out = 1 and stall_in = 0; simultaneous push and pop leaves occupancy unchanged.
REQ-022 branch_taken_in SHALL clear the FIFO, load pc_q = {target[31:2],2'b00}, and move WAIT -> DROP; DROP stays DROP; IDLE issues no request that cycle.
REQ-023 branch_taken_in coincident with imem_ack_in SHALL discard the response (takes priority over push).
REQ-024 flush_out SHALL equal NOT instr_valid_out.
REQ-025 Latency: request at cycle N, ack at N+1 -> instr_valid_out at N+2.

Reset
REQ-026 Reset SHALL give pc_q = BOOT_ADDR, state IDLE, FIFO empty, instr_valid_out 0, instr_out 32'h00000013, instr_pc_out 0, flush_out 1, imem_req_out 0 while asserted.
REQ-027 Reset mid-transaction SHALL abandon the outstanding request; a late ack after release SHALL be ignored (IDLE).

Configuration
REQ-028 Macro MSRV32_FETCH_PERF_EN defined: adds output perf_bubble_cnt_out [31:0], reset 0, incremented each cycle with instr_valid_out = 0 and stall_in = 0, saturating at 32'hFFFF_FFFF.
REQ-029 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, NOP constant 32'h00000013 and default boot address.
REQ-031 FIFO SHALL be a sub-module msrv32_fetch_fifo (2 entries, 64-bit payload, push/pop/clear, count).

Verification
REQ-032 Reset release, memory acks every request next cycle, stall_in = 0 -> instr_pc_out 0,4,8,... one per 2 cycles, first valid 2 cycles after release.
REQ-033 stall_in held 1 -> FIFO fills to 2, imem_req_out stays 0, head stays PC 0 with instr stable.
REQ-034 Branch to 32'h0000_0103 while WAIT -> next ack dropped, next request address 32'h0000_0100, FIFO empty, flush_out 1.
REQ-035 Branch and ack same cycle -> response not visible, next fetch from target.
REQ-036 Assert reset during WAIT, then ack after release -> no push, first request address BOOT_ADDR.
REQ-037 With MSRV32_FETCH_PERF_EN, 5 bubble cycles, stall_in = 0 -> perf_bubble_cnt_out = 5; stalled cycles not counted.

Source files
------------

// File: rtl/msrv32_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding, queue entry layout, NOP word, boot address.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msrv32_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,     // no request outstanding
        ST_WAIT = 2'd1,     // one request outstanding, response will be kept
        ST_DROP = 2'd2      // one request outstanding, response will be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0]  NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0]  DEFAULT_BOOT_ADDR = 32'h0000_0000;
    localparam fetch_entry_t RESET_ENTRY       = {32'h0000_0000, NOP_INSTR};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Two-entry {pc, instr} queue with push/pop/clear; entry 0 is always the head.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: push is ignored when full (unless popped the same cycle); clear wins over push/pop.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clear flush; i_push/i_push_dat write;
//        i_pop remove head; o_head_dat head payload; o_count occupancy 0..2.
module msrv32_fetch_fifo
    import msrv32_fetch_queue_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [63:0] i_push_dat,
    input  logic        i_pop,
    output logic [63:0] o_head_dat,
    output logic [1:0]  o_count
);

    logic [63:0] r_ent0;
    logic [63:0] r_ent1;
    logic [1:0]  r_count;
    logic        w_pop_ok;
    logic        w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ent0  <= RESET_ENTRY;
            r_ent1  <= RESET_ENTRY;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= i_push_dat;
                    else                 r_ent1 <= i_push_dat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: new word lands behind whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_push_dat;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head_dat = r_ent0;
    assign o_count    = r_count;

endmodule

// File: rtl/msrv32_fetch_queue.sv
// Instruction fetch front end: issues one word fetch at a time into a 2-entry queue feeding decode.
// Latency: request cycle N, ack cycle N+1, instruction at head in cycle N+2.
// Backpressure: stall_in holds the head; fetching pauses while the queue holds 2 entries.
// Ports: ms_riscv32_mp_clk_in/ms_riscv32_mp_rst_in clock and async active-low reset;
//        imem_* instruction memory request/response; branch_* redirect from execute;
//        stall_in decode hold; instr_*_out head entry to decode; flush_out = no valid head.
// Optional: MSRV32_FETCH_PERF_EN adds perf_bubble_cnt_out (saturating count of unstalled empty cycles).
module msrv32_fetch_queue
    import msrv32_fetch_queue_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        stall_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
`ifdef MSRV32_FETCH_PERF_EN
    output logic [31:0] perf_bubble_cnt_out,
`endif
    output logic        flush_out
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_issued_pc;
    logic         w_req;
    logic         w_push;
    logic         w_pop;
    logic         w_valid;
    logic [1:0]   w_count;
    logic [63:0]  w_head_dat;
    fetch_entry_t w_head;
    fetch_entry_t w_push_ent;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!branch_taken_in && (w_count != 2'd2)) begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_in) begin
                    // A redirect in the ack cycle makes this word stale.
                    w_push      = !branch_taken_in;
                    w_state_nxt = ST_IDLE;
                end else if (branch_taken_in) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_ack_in) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_state     <= ST_IDLE;
            r_pc        <= BOOT_ADDR;
            r_issued_pc <= BOOT_ADDR;
        end else begin
            r_state <= w_state_nxt;
            if (branch_taken_in)  r_pc <= word_align(branch_target_in);
            else if (w_req)       r_pc <= r_pc + 32'd4;
            if (w_req)            r_issued_pc <= r_pc;
        end
    end

    assign w_push_ent = '{pc: r_issued_pc, instr: imem_rdata_in};
    assign w_valid    = (w_count != 2'd0);
    assign w_pop      = w_valid && !stall_in;

    msrv32_fetch_fifo u_fifo (
        .i_clk      (ms_riscv32_mp_clk_in),
        .i_rst_n    (ms_riscv32_mp_rst_in),
        .i_clear    (branch_taken_in),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_count    (w_count)
    );

    assign w_head = w_head_dat;

    // Request is combinational from IDLE, so gate it to stay quiet while reset is held.
    assign imem_req_out    = w_req && ms_riscv32_mp_rst_in;
    assign imem_addr_out   = r_pc;
    assign instr_valid_out = w_valid;
    assign instr_out       = w_valid ? w_head.instr : NOP_INSTR;
    assign instr_pc_out    = w_valid ? w_head.pc : 32'h0000_0000;
    assign flush_out       = !w_valid;

`ifdef MSRV32_FETCH_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_bubble_cnt <= 32'h0000_0000;
        end else if (!w_valid && !stall_in && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt_out = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_msrv32_fetch_queue.sv
module tb_msrv32_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        stall_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        flush_out;
`ifdef MSRV32_FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt_out;
`endif

    int checks = 0;
    int errors = 0;
    logic mem_auto = 1'b0;

    always #5 clk = ~clk;

    msrv32_fetch_queue #(.BOOT_ADDR(32'h0000_0000)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_ack_in          (imem_ack_in),
        .imem_rdata_in        (imem_rdata_in),
        .branch_taken_in      (branch_taken_in),
        .branch_target_in     (branch_target_in),
        .stall_in             (stall_in),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
`ifdef MSRV32_FETCH_PERF_EN
        .perf_bubble_cnt_out  (perf_bubble_cnt_out),
`endif
        .flush_out            (flush_out)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock: sample the request at the falling edge, then (in auto mode) answer it next cycle.
    task automatic tick();
        logic        req_s;
        logic [31:0] addr_s;
        @(negedge clk);
        req_s  = imem_req_out;
        addr_s = imem_addr_out;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_ack_in   = req_s;
            imem_rdata_in = instr_of(addr_s);
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        imem_ack_in      = 1'b0;
        imem_rdata_in    = 32'h0;
        branch_taken_in  = 1'b0;
        branch_target_in = 32'h0;
        stall_in         = 1'b0;
        mem_auto         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        imem_ack_in      = 1'b0;
        imem_rdata_in    = 32'h0;
        branch_taken_in  = 1'b0;
        branch_target_in = 32'h0;
        stall_in         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_out); end
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_out); end
        checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr_out); end
        checks++; if (instr_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", instr_pc_out); end
        checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b expected 1", flush_out); end
`ifdef MSRV32_FETCH_PERF_EN
        checks++; if (perf_bubble_cnt_out !== 32'h0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_bubble_cnt_out); end
`endif
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
            errors++; $display("FAIL first_req: got req %b addr %h expected 1 00000000", imem_req_out, imem_addr_out);
        end
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [31:0] exp_pc;
        do_reset();
        mem_auto = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_v  = (k % 2 == 0);
            exp_pc = 32'((k / 2 - 1) * 4);
            checks++; if (instr_valid_out !== exp_v || flush_out !== !exp_v) begin
                errors++; $display("FAIL stream_valid[%0d]: got v %b f %b expected v %b", k, instr_valid_out, flush_out, exp_v);
            end
            if (exp_v) begin
                checks++; if (instr_pc_out !== exp_pc || instr_out !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL stream_head[%0d]: got pc %h instr %h expected pc %h instr %h",
                                       k, instr_pc_out, instr_out, exp_pc, instr_of(exp_pc));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_auto = 1'b1;
        stall_in = 1'b1;
        repeat (3) tick();
        for (int k = 4; k <= 8; k++) begin
            tick();
            checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h0 || instr_out !== instr_of(32'h0)) begin
                errors++; $display("FAIL stall_head[%0d]: got v %b pc %h instr %h expected 1 00000000 %h",
                                   k, instr_valid_out, instr_pc_out, instr_out, instr_of(32'h0));
            end
            checks++; if (imem_req_out !== 1'b0) begin
                errors++; $display("FAIL stall_req[%0d]: got %b expected 0", k, imem_req_out);
            end
        end
        stall_in = 1'b0;
        tick();
        checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h4 || instr_out !== instr_of(32'h4)) begin
            errors++; $display("FAIL stall_second: got v %b pc %h instr %h expected 1 00000004 %h",
                               instr_valid_out, instr_pc_out, instr_out, instr_of(32'h4));
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        tick();
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0000_0103;
        #1;
        checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL bw_req_wait: got %b expected 0", imem_req_out); end
        tick();
        branch_taken_in = 1'b0;
        imem_ack_in     = 1'b1;
        imem_rdata_in   = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req_out !== 1'b0) begin errors++; $display("FAIL bw_req_drop: got %b expected 0", imem_req_out); end
        tick();
        imem_ack_in = 1'b0;
        #1;
        checks++; if (instr_valid_out !== 1'b0 || flush_out !== 1'b1) begin
            errors++; $display("FAIL bw_dropped: got v %b f %b expected 0 1", instr_valid_out, flush_out);
        end
        checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0000_0100) begin
            errors++; $display("FAIL bw_target: got req %b addr %h expected 1 00000100", imem_req_out, imem_addr_out);
        end
        tick();
        imem_ack_in   = 1'b1;
        imem_rdata_in = instr_of(32'h100);
        tick();
        imem_ack_in = 1'b0;
        checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h100 || instr_out !== instr_of(32'h100)) begin
            errors++; $display("FAIL bw_fetch: got v %b pc %h instr %h expected 1 00000100 %h",
                               instr_valid_out, instr_pc_out, instr_out, instr_of(32'h100));
        end
    endtask

    task automatic test_branch_clear();
        do_reset();
        mem_auto = 1'b1;
        stall_in = 1'b1;
        repeat (4) tick();
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0000_0040;
        tick();
        branch_taken_in = 1'b0;
        stall_in        = 1'b0;
        #1;
        checks++; if (instr_valid_out !== 1'b0 || flush_out !== 1'b1 || instr_out !== 32'h13) begin
            errors++; $display("FAIL bc_clear: got v %b f %b instr %h expected 0 1 00000013", instr_valid_out, flush_out, instr_out);
        end
        repeat (2) tick();
        checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h40) begin
            errors++; $display("FAIL bc_refetch: got v %b pc %h expected 1 00000040", instr_valid_out, instr_pc_out);
        end
    endtask

    task automatic test_branch_ack();
        do_reset();
        tick();
        imem_ack_in      = 1'b1;
        imem_rdata_in    = 32'h1111_1111;
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0000_0200;
        tick();
        imem_ack_in     = 1'b0;
        branch_taken_in = 1'b0;
        #1;
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL ba_hidden: got v %b expected 0", instr_valid_out); end
        checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin
            errors++; $display("FAIL ba_target: got req %b addr %h expected 1 00000200", imem_req_out, imem_addr_out);
        end
        tick();
        imem_ack_in   = 1'b1;
        imem_rdata_in = instr_of(32'h200);
        tick();
        imem_ack_in = 1'b0;
        checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h200 || instr_out !== instr_of(32'h200)) begin
            errors++; $display("FAIL ba_fetch: got v %b pc %h instr %h expected 1 00000200 %h",
                               instr_valid_out, instr_pc_out, instr_out, instr_of(32'h200));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin
            errors++; $display("FAIL rm_in_reset: got req %b v %b expected 0 0", imem_req_out, instr_valid_out);
        end
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        imem_ack_in   = 1'b1;
        imem_rdata_in = 32'hBAD0_0BAD;
        #1;
        checks++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin
            errors++; $display("FAIL rm_boot_req: got req %b addr %h expected 1 00000000", imem_req_out, imem_addr_out);
        end
        tick();
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got v %b expected 0", instr_valid_out); end
        imem_rdata_in = instr_of(32'h0);
        tick();
        imem_ack_in = 1'b0;
        checks++; if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h0 || instr_out !== instr_of(32'h0)) begin
            errors++; $display("FAIL rm_fetch: got v %b pc %h instr %h expected 1 00000000 %h",
                               instr_valid_out, instr_pc_out, instr_out, instr_of(32'h0));
        end
    endtask

`ifdef MSRV32_FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        repeat (5) tick();
        checks++; if (perf_bubble_cnt_out !== 32'd5) begin errors++; $display("FAIL perf_count: got %0d expected 5", perf_bubble_cnt_out); end
        stall_in = 1'b1;
        repeat (3) tick();
        stall_in = 1'b0;
        checks++; if (perf_bubble_cnt_out !== 32'd5) begin errors++; $display("FAIL perf_stalled: got %0d expected 5", perf_bubble_cnt_out); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_wait();
        test_branch_clear();
        test_branch_ack();
        test_reset_mid();
`ifdef MSRV32_FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
